mccoy_prog_feeder: RTL and testbench
====================================

MCCOY_PROG_FEEDER -- requirements
Module: mccoy_prog_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, giving program memory entries (power of two, 2..256).
REQ-002 SHALL have parameter MAX_CYCLES, default 255, giving the run-cycle budget before forced halt (1..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock for all state; core clock is the same net.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port load_valid, input, 1 bit: load word offered.
REQ-006 SHALL have port load_data, input, 6 bits: instruction word to store.
REQ-007 SHALL have port load_last, input, 1 bit: qualifies final load word.
REQ-008 SHALL have port load_ready, output, 1 bit: feeder accepts load word.
REQ-009 SHALL have port run, input, 1 bit: start execution request.
REQ-010 SHALL have port pc_in, input, 8 bits: core program counter.
REQ-011 SHALL have port instr_out, output, 6 bits: instruction presented to the core.
REQ-012 SHALL have port core_reset, output, 1 bit: reset driven to the core.
REQ-013 SHALL have port busy, output, 1 bit: high in LOAD or RUN.
REQ-014 SHALL have port done, output, 1 bit: high in HALT.
REQ-015 SHALL have port cycles, output, 8 bits: executed run cycles.

Function
REQ-016 SHALL implement states IDLE, LOAD, BOOT, RUN, HALT.
REQ-017 IDLE: load_valid=1 -> LOAD with write pointer 0; else run=1 -> BOOT; load_valid wins if both high.
REQ-018 LOAD: load_ready=1; word written to mem[wptr] on cycle with load_valid&load_ready; wptr increments by 1.
REQ-019 LOAD exits to IDLE after the transfer with load_last=1 or the transfer writing entry DEPTH-1, whichever first; load_ready=0 in the following cycle.
REQ-020 Entries not written since reset SHALL read 6'b000000.
REQ-021 BOOT: core_reset=1 for exactly 2 cycles, cycles cleared to 0, then -> RUN.
REQ-022 RUN: core_reset=0; instr_out = mem[pc_in mod DEPTH], combinational from pc_in (zero-cycle latency).
REQ-023 Outside RUN, instr_out SHALL be 6'b000000.
REQ-024 RUN: cycles increments once per clk; transition to HALT on the cycle cycles reaches MAX_CYCLES.
REQ-025 HALT: core_reset=1, done=1, cycles frozen; run=1 -> BOOT (re-run same program); load_valid=1 -> LOAD (load_valid wins).
REQ-026 run and load_valid SHALL be ignored in LOAD, BOOT and RUN.
REQ-027 busy = (state==LOAD or BOOT or RUN); done = (state==HALT); both registered state decodes.

Reset
REQ-028 reset asserted at any time, including mid-LOAD or mid-RUN, SHALL immediately force IDLE, wptr=0, cycles=0, core_reset=1, load_ready=0, busy=0, done=0, instr_out=0.
REQ-029 reset SHALL clear all program memory entries to 0.
REQ-030 core_reset SHALL be 1 in IDLE, LOAD, BOOT, HALT and 0 only in RUN.

Configuration
REQ-031 Macro MCCOY_FEEDER_BOUNDS_EN defined: in RUN, pc_in >= DEPTH forces HALT on the next clk edge and instr_out=0 in that cycle.
REQ-032 Macro MCCOY_FEEDER_BOUNDS_EN undefined: pc_in wraps modulo DEPTH with no halt; only MAX_CYCLES ends RUN.

Verification
REQ-033 Reset mid-LOAD after 3 words -> IDLE next observation, load_ready=0, mem[0..2] read 0 after subsequent run.
REQ-034 Load 4 words 0x05,0x0A,0x11,0x3F with load_last on 4th -> load_ready drops after 4th transfer; run -> core_reset high 2 cycles; pc_in=2 -> instr_out=0x11.
REQ-035 Load 40 words with DEPTH=32 -> exactly 32 accepted, load_ready=0 after 32nd, IDLE reached.
REQ-036 MAX_CYCLES=10, run -> HALT after 10 RUN cycles, done=1, cycles=10, core_reset=1; run again -> cycles restarts at 0.
REQ-037 MCCOY_FEEDER_BOUNDS_EN defined, pc_in=40 in RUN -> HALT next edge, instr_out=0; undefined -> instr_out=mem[8], remains RUN.
REQ-038 load_valid and run both high in IDLE -> LOAD entered, run ignored.

Source files
------------

// File: rtl/mccoy_prog_feeder_if.sv
// Load/run handshake and core-facing signals of the McCoy program feeder.
interface mccoy_prog_feeder_if;
  logic       load_valid;
  logic [5:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       run;
  logic [7:0] pc_in;
  logic [5:0] instr_out;
  logic       core_reset;
  logic       busy;
  logic       done;
  logic [7:0] cycles;

  modport master (
    output load_valid, load_data, load_last, run, pc_in,
    input  load_ready, instr_out, core_reset, busy, done, cycles
  );

  modport slave (
    input  load_valid, load_data, load_last, run, pc_in,
    output load_ready, instr_out, core_reset, busy, done, cycles
  );
endinterface

// File: rtl/mccoy_prog_feeder.sv
// Program feeder: loads instruction words, boots the core and serves instructions by PC.
// Optional macro MCCOY_FEEDER_BOUNDS_EN halts the run when pc_in falls outside the memory.
module mccoy_prog_feeder #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned MAX_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  mccoy_prog_feeder_if.slave bus
);

  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]    MaxCyc  = 8'(MAX_CYCLES);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StBoot, StRun, StHalt} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [7:0]    cycles_q, cycles_d;
  logic          boot_cnt_q, boot_cnt_d;
  logic          mem_we;
  logic          pc_oob;
  logic [5:0]    mem_q [DEPTH];
  logic          unused_pc;

`ifdef MCCOY_FEEDER_BOUNDS_EN
  assign pc_oob = ({1'b0, bus.pc_in} >= 9'(DEPTH));
`else
  assign pc_oob = 1'b0;
`endif

  // Upper PC bits only matter to the bounds check.
  assign unused_pc = ^bus.pc_in;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    cycles_d   = cycles_q;
    boot_cnt_d = boot_cnt_q;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle, StHalt: begin
        if (bus.load_valid) begin
          state_d = StLoad;
          wptr_d  = '0;
        end else if (bus.run) begin
          state_d    = StBoot;
          boot_cnt_d = 1'b0;
          cycles_d   = '0;
        end
      end
      StLoad: begin
        if (bus.load_valid) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (bus.load_last || (wptr_q == LastIdx)) state_d = StIdle;
        end
      end
      StBoot: begin
        // Two-cycle core reset pulse; boot_cnt_q marks the second cycle.
        cycles_d   = '0;
        boot_cnt_d = !boot_cnt_q;
        if (boot_cnt_q) state_d = StRun;
      end
      StRun: begin
        cycles_d = cycles_q + 8'd1;
        if ((cycles_d == MaxCyc) || pc_oob) state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      cycles_q   <= '0;
      boot_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      cycles_q   <= cycles_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wptr_q] <= bus.load_data;
    end
  end

  assign bus.load_ready = (state_q == StLoad);
  assign bus.busy       = (state_q == StLoad) || (state_q == StBoot) || (state_q == StRun);
  assign bus.done       = (state_q == StHalt);
  assign bus.core_reset = (state_q != StRun);
  assign bus.cycles     = cycles_q;
  assign bus.instr_out  = ((state_q == StRun) && !pc_oob) ? mem_q[bus.pc_in[AW-1:0]] : 6'b000000;

endmodule

// File: tb/tb_mccoy_prog_feeder.sv
// Self-checking bench for mccoy_prog_feeder (DEPTH=32, MAX_CYCLES=10) with an instruction scoreboard.
module tb_mccoy_prog_feeder;

  localparam int DEPTH = 32;
  localparam int MAXC  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mccoy_prog_feeder_if bus ();

  mccoy_prog_feeder #(
    .DEPTH      (DEPTH),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_mem [DEPTH];
  logic [5:0] words [$];
  int         rd_addr [$];
  logic [5:0] sb [$];

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 6'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.load_valid = 1'b0; bus.load_last = 1'b0; bus.run = 1'b0; bus.pc_in = 8'd0;
    clear_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Offers words[] until all are sent or the feeder leaves LOAD; returns at a negedge.
  task automatic do_load(input bit use_last, output int accepted);
    int   i;
    logic rdy;
    i = 0;
    accepted = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (i >= words.size() || (accepted > 0 && !bus.load_ready)) begin
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        return;
      end
      bus.load_valid = 1'b1;
      bus.load_data  = words[i];
      bus.load_last  = use_last && (i == words.size() - 1);
      rdy = bus.load_ready;
      @(posedge clk);
      if (rdy) begin
        if (accepted < DEPTH) exp_mem[accepted] = words[i];
        accepted++;
        i++;
      end
    end
    checks++; errors++;
    $display("FAIL load_timeout accepted=%0d", accepted);
    bus.load_valid = 1'b0;
  endtask

  // Requests a run and checks the two-cycle boot pulse; returns at the first RUN negedge.
  task automatic start_run();
    @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    checks++;
    if (bus.core_reset !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL boot1 core_reset=%b busy=%b want 1 1", bus.core_reset, bus.busy);
    end
    checks++;
    if (bus.cycles !== 8'd0) begin
      errors++; $display("FAIL boot_cycles_clear got=%0d want=0", bus.cycles);
    end
    @(negedge clk);
    checks++;
    if (bus.core_reset !== 1'b1) begin
      errors++; $display("FAIL boot2 core_reset=%b want 1", bus.core_reset);
    end
    @(negedge clk);
    checks++;
    if (bus.core_reset !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL run_entry core_reset=%b busy=%b done=%b want 0 1 0",
                         bus.core_reset, bus.busy, bus.done);
    end
  endtask

  task automatic read_addrs();
    logic [5:0] e;
    foreach (rd_addr[k]) begin
      sb.push_back(exp_mem[rd_addr[k] % DEPTH]);
      bus.pc_in = 8'(rd_addr[k]);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.instr_out !== e) begin
        errors++; $display("FAIL instr pc=%0d got=%h want=%h", rd_addr[k], bus.instr_out, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_halt(input bit chk_cycles);
    for (int n = 0; n < 40 && bus.done !== 1'b1; n++) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.core_reset !== 1'b1) begin
      errors++; $display("FAIL halt done=%b busy=%b core_reset=%b want 1 0 1",
                         bus.done, bus.busy, bus.core_reset);
    end
    checks++;
    if (bus.instr_out !== 6'h00) begin
      errors++; $display("FAIL halt_instr got=%h want=00", bus.instr_out);
    end
    if (chk_cycles) begin
      checks++;
      if (bus.cycles !== 8'(MAXC)) begin
        errors++; $display("FAIL halt_cycles got=%0d want=%0d", bus.cycles, MAXC);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.load_valid = 1'b0; bus.load_last = 1'b0; bus.load_data = 6'h00;
    bus.run = 1'b0; bus.pc_in = 8'd0;
    clear_model();
    #1;
    checks++;
    if (bus.load_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.core_reset !== 1'b1 || bus.cycles !== 8'd0 || bus.instr_out !== 6'h00) begin
      errors++; $display("FAIL reset_state rdy=%b busy=%b done=%b cr=%b cyc=%0d instr=%h",
                         bus.load_ready, bus.busy, bus.done, bus.core_reset, bus.cycles,
                         bus.instr_out);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.core_reset !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset busy=%b cr=%b want 0 1", bus.busy, bus.core_reset);
    end
  endtask

  task automatic test_load_run();
    int acc;
    words = '{6'h05, 6'h0A, 6'h11, 6'h3F};
    do_load(1'b1, acc);
    checks++;
    if (acc !== 4) begin
      errors++; $display("FAIL load4_count got=%0d want=4", acc);
    end
    checks++;
    if (bus.load_ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL load4_exit rdy=%b busy=%b want 0 0", bus.load_ready, bus.busy);
    end
    start_run();
    rd_addr = '{2, 0, 1, 3, 9};
    read_addrs();
    wait_halt(1'b1);
    // Re-run from HALT restarts the cycle count.
    start_run();
    rd_addr = '{2};
    read_addrs();
    wait_halt(1'b1);
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk);
    bus.load_valid = 1'b1; bus.run = 1'b1; bus.load_data = 6'h2A; bus.load_last = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++; $display("FAIL prio_load got_rdy=%b want 1", bus.load_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.load_ready !== 1'b1 || bus.core_reset !== 1'b1) begin
      errors++; $display("FAIL run_ignored_in_load rdy=%b cr=%b want 1 1",
                         bus.load_ready, bus.core_reset);
    end
    bus.run = 1'b0; bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    exp_mem[0] = 6'h2A;
    checks++;
    if (bus.load_ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL prio_exit rdy=%b busy=%b want 0 0", bus.load_ready, bus.busy);
    end
  endtask

  task automatic test_overflow();
    int acc;
    words = {};
    for (int i = 0; i < 40; i++) words.push_back(6'((i * 7 + 3) & 63));
    do_load(1'b0, acc);
    checks++;
    if (acc !== DEPTH) begin
      errors++; $display("FAIL overflow_count got=%0d want=%0d", acc, DEPTH);
    end
    checks++;
    if (bus.load_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL overflow_exit rdy=%b busy=%b done=%b want 0 0 0",
                         bus.load_ready, bus.busy, bus.done);
    end
    start_run();
    rd_addr = '{0, 31, 8, 16};
    read_addrs();
    wait_halt(1'b1);
  endtask

  task automatic test_bounds();
    start_run();
    rd_addr = '{5};
    read_addrs();
    bus.pc_in = 8'd40;
    #1;
`ifdef MCCOY_FEEDER_BOUNDS_EN
    checks++;
    if (bus.instr_out !== 6'h00) begin
      errors++; $display("FAIL bounds_instr got=%h want=00", bus.instr_out);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.core_reset !== 1'b1) begin
      errors++; $display("FAIL bounds_halt done=%b cr=%b want 1 1", bus.done, bus.core_reset);
    end
    wait_halt(1'b0);
`else
    checks++;
    if (bus.instr_out !== exp_mem[8]) begin
      errors++; $display("FAIL wrap_instr got=%h want=%h", bus.instr_out, exp_mem[8]);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL wrap_stays_run busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    wait_halt(1'b1);
`endif
    bus.pc_in = 8'd0;
  endtask

  task automatic test_reset_mid_load();
    int acc;
    words = '{6'h15, 6'h16, 6'h17};
    do_load(1'b0, acc);
    checks++;
    if (acc !== 3 || bus.load_ready !== 1'b1) begin
      errors++; $display("FAIL midload_setup acc=%0d rdy=%b want 3 1", acc, bus.load_ready);
    end
    reset = 1'b1;
    clear_model();
    #1;
    checks++;
    if (bus.load_ready !== 1'b0 || bus.busy !== 1'b0 || bus.core_reset !== 1'b1) begin
      errors++; $display("FAIL midload_reset rdy=%b busy=%b cr=%b want 0 0 1",
                         bus.load_ready, bus.busy, bus.core_reset);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.load_ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midload_idle rdy=%b busy=%b want 0 0", bus.load_ready, bus.busy);
    end
    start_run();
    rd_addr = '{0, 1, 2};
    read_addrs();
    wait_halt(1'b1);
  endtask

  initial begin
    reset = 1'b0;
    bus.load_valid = 1'b0; bus.load_last = 1'b0; bus.load_data = 6'h00;
    bus.run = 1'b0; bus.pc_in = 8'd0;
    test_reset();
    test_load_run();
    test_priority();
    test_overflow();
    test_bounds();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
